fetch_controller: RTL and testbench

- Sequences the combinational instruction memory: owns the fetch PC, drives the memory address, and buffers fetched words in a small prefetch queue.
- Delivers queued words to decode over a valid/ready handshake.
- Sits between instruction_memory and the decode stage.
- Handles branch/jump redirects by flushing the queue, and supports a halt/resume request from the core.

---
 rtl/fetch_controller_pkg.sv | 17 +
 rtl/fetch_queue.sv | 72 +++++++
 rtl/fetch_controller.sv | 101 ++++++++++
 tb/tb_fetch_controller.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_controller_pkg.sv
// Shared constants and FSM encoding for the instruction fetch controller.
//   FC_ADDR_W   : byte address width of the instruction memory
//   FC_INST_W   : instruction width
//   FC_RESET_PC : fetch PC after reset (must be halfword aligned)
//   fc_state_e  : fetch FSM states
package fetch_controller_pkg;

    localparam int unsigned FC_ADDR_W = 9;
    localparam int unsigned FC_INST_W = 16;
    localparam logic [FC_ADDR_W-1:0] FC_RESET_PC = 9'h000;

    typedef enum logic {
        FC_RUN    = 1'b0,
        FC_HALTED = 1'b1
    } fc_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Parameterised synchronous FIFO used as the instruction prefetch queue.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset (empties the queue)
//   flush : empties the queue; has priority over push and pop
//   push  : write din at the tail (ignored when full unless popping)
//   din   : entry to write
//   pop   : drop the head entry (ignored when empty)
//   dout  : head entry, forced to 0 while empty so no X leaks out
//   count : number of valid entries
module fetch_queue #(
    parameter int unsigned WIDTH = 25,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic             do_pop;
    logic             do_push;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop && (count_q != '0);
    // A full queue can still accept a write when the head leaves in the same cycle.
    assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                tail_q <= next_ptr(tail_q);
            end
            if (do_pop) begin
                head_q <= next_ptr(head_q);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: dout is masked whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push) begin
            mem_q[tail_q] <= din;
        end
    end

    assign dout  = (count_q != '0) ? mem_q[head_q] : '0;
    assign count = count_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: owns the fetch PC, addresses the combinational
// instruction memory, buffers fetched words in a prefetch queue and hands them
// to decode over a valid/ready handshake.
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   imem_addr         : halfword-aligned byte address to instruction memory
//   imem_inst         : combinational read data for imem_addr
//   if_valid/if_ready : handshake with decode
//   if_inst, if_pc    : head instruction and its byte address (0 when empty)
//   redirect          : one-cycle pulse; flush queue and jump to redirect_pc
//   redirect_pc       : redirect target (bit 0 ignored)
//   halt              : level request to stop issuing new fetches
//   halted            : FSM halted and queue fully drained
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter int unsigned       ADDR_W   = FC_ADDR_W,
    parameter int unsigned       INST_W   = FC_INST_W,
    parameter int unsigned       DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FC_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_inst,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [INST_W-1:0] if_inst,
    output logic [ADDR_W-1:0] if_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              halted
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fc_state_e                  state_q, state_d;
    logic [ADDR_W-1:0]          fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]           count;
    logic [ADDR_W+INST_W-1:0]   head;
    logic                       pop;
    logic                       push;
    logic                       unused_lsbs;

    assign imem_addr = {fetch_pc_q[ADDR_W-1:1], 1'b0};
    assign if_valid  = (count != '0);
    assign pop       = if_valid && if_ready;
    assign if_pc     = head[ADDR_W+INST_W-1:INST_W];
    assign if_inst   = head[INST_W-1:0];
    assign halted    = (state_q == FC_HALTED) && (count == '0);

    // PC bit 0 never reaches the memory; the target's bit 0 is dropped.
    assign unused_lsbs = redirect_pc[0] ^ fetch_pc_q[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FC_RUN;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        // halt sampled on this edge already blocks the fetch, not just the next one.
        push = (state_q == FC_RUN) && !halt && !redirect &&
               ((count < CNT_W'(DEPTH)) || pop);

        unique case (state_q)
            FC_RUN:    if (halt)  state_d = FC_HALTED;
            FC_HALTED: if (!halt) state_d = FC_RUN;
            default:   state_d = FC_RUN;
        endcase

        if (redirect) begin
            fetch_pc_d = {redirect_pc[ADDR_W-1:1], 1'b0};
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(2);
        end
    end

    // Redirect drives flush, which overrides any push/pop in the same cycle.
    fetch_queue #(
        .WIDTH(ADDR_W + INST_W),
        .DEPTH(DEPTH)
    ) u_queue (
        .clk  (clk),
        .rst  (rst),
        .flush(redirect),
        .push (push),
        .din  ({imem_addr, imem_inst}),
        .pop  (pop),
        .dout (head),
        .count(count)
    );

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned INST_W = 16;
    localparam int unsigned DEPTH  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_inst;
    logic              if_valid;
    logic              if_ready;
    logic [INST_W-1:0] if_inst;
    logic [ADDR_W-1:0] if_pc;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt;
    logic              halted;

    logic [INST_W-1:0] mem [256];

    // Reference state: queue of {pc, inst}, next PC to fetch, fetching enabled.
    logic [24:0]       ref_q[$];
    logic [24:0]       log_q[$];
    logic [8:0]        ref_pc  = 9'h000;
    logic              ref_run = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign imem_inst = mem[imem_addr[8:1]];

    fetch_controller #(
        .ADDR_W  (ADDR_W),
        .INST_W  (INST_W),
        .DEPTH   (DEPTH),
        .RESET_PC(9'h000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_inst  (imem_inst),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_inst    (if_inst),
        .if_pc      (if_pc),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halt       (halt),
        .halted     (halted)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_log(input int idx, input logic [8:0] pc, input logic [15:0] inst);
        if (idx < log_q.size()) begin
            check("log_pc", 32'(log_q[idx][24:16]), 32'(pc));
            check("log_inst", 32'(log_q[idx][15:0]), 32'(inst));
        end else begin
            check("log_len", 32'(log_q.size()), 32'(idx + 1));
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Behavioural model: one update per rising edge from the inputs held over it.
    task automatic model_step();
        logic do_pop;
        logic do_push;
        if (rst) begin
            ref_q.delete();
            ref_pc  = 9'h000;
            ref_run = 1'b1;
        end else begin
            do_pop = (ref_q.size() != 0) && if_ready;
            if (redirect) begin
                ref_q.delete();
                ref_pc = {redirect_pc[8:1], 1'b0};
            end else begin
                do_push = ref_run && !halt && ((ref_q.size() < DEPTH) || do_pop);
                if (do_pop) void'(ref_q.pop_front());
                if (do_push) begin
                    ref_q.push_back({ref_pc, mem[ref_pc[8:1]]});
                    ref_pc = ref_pc + 9'd2;
                end
            end
            ref_run = !halt;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Monitor: compares DUT outputs with the model's queue head and logs handshakes.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("if_valid", 32'(if_valid), 32'(ref_q.size() != 0));
            check("imem_addr", 32'(imem_addr), 32'(ref_pc));
            check("halted", 32'(halted), 32'(!ref_run && ref_q.size() == 0));
            if (ref_q.size() != 0) begin
                check("if_pc", 32'(if_pc), 32'(ref_q[0][24:16]));
                check("if_inst", 32'(if_inst), 32'(ref_q[0][15:0]));
            end else begin
                check("if_pc_idle", 32'(if_pc), 32'h0);
                check("if_inst_idle", 32'(if_inst), 32'h0);
            end
            if (if_valid && if_ready && !redirect && !rst) log_q.push_back({if_pc, if_inst});
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[0]   = 16'h1234;
        mem[1]   = 16'h5678;
        mem[2]   = 16'h9ABC;
        mem[3]   = 16'hDEF0;
        mem[255] = 16'hBEEF;

        rst = 1'b1; if_ready = 1'b1; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;

        // In-order delivery after reset.
        step(2);
        log_q.delete();
        rst = 1'b0;
        step(5);
        check_log(0, 9'h000, 16'h1234);
        check_log(1, 9'h002, 16'h5678);
        check_log(2, 9'h004, 16'h9ABC);
        check_log(3, 9'h006, 16'hDEF0);

        // Back-pressure: queue fills and the fetch address holds.
        rst = 1'b1;
        step(1);
        log_q.delete();
        rst = 1'b0; if_ready = 1'b0;
        step(5);
        check("full_addr_hold", 32'(imem_addr), 32'h004);
        if_ready = 1'b1;
        step(3);
        check("bp_log_len", 32'(log_q.size()), 32'd3);
        check_log(0, 9'h000, 16'h1234);
        check_log(1, 9'h002, 16'h5678);
        check_log(2, 9'h004, 16'h9ABC);

        // Redirect on a full queue; odd target is aligned down.
        rst = 1'b1;
        step(1);
        rst = 1'b0; if_ready = 1'b0;
        step(4);
        log_q.delete();
        redirect = 1'b1; redirect_pc = 9'h005; if_ready = 1'b1;
        step(1);
        redirect = 1'b0;
        check("redir_gap_valid", 32'(if_valid), 32'h0);
        step(1);
        check("redir_valid", 32'(if_valid), 32'h1);
        check("redir_pc", 32'(if_pc), 32'h004);
        check("redir_inst", 32'(if_inst), 32'h9ABC);
        step(1);
        check_log(0, 9'h004, 16'h9ABC);

        // PC wrap from 1FE to 000.
        redirect = 1'b1; redirect_pc = 9'h1FE;
        step(1);
        redirect = 1'b0;
        log_q.delete();
        step(3);
        check_log(0, 9'h1FE, 16'hBEEF);
        check_log(1, 9'h000, 16'h1234);

        // Halt drains the queue, then resumes sequentially.
        rst = 1'b1;
        step(1);
        rst = 1'b0; if_ready = 1'b0;
        step(3);
        log_q.delete();
        halt = 1'b1; if_ready = 1'b1;
        step(4);
        check("halt_drained", 32'(log_q.size()), 32'd2);
        check("halted_high", 32'(halted), 32'h1);
        check("halt_addr_hold", 32'(imem_addr), 32'h004);
        halt = 1'b0;
        step(3);
        check_log(2, 9'h004, 16'h9ABC);

        // Reset mid-stream.
        rst = 1'b1;
        step(1);
        check("rst_valid", 32'(if_valid), 32'h0);
        check("rst_inst", 32'(if_inst), 32'h0);
        check("rst_pc", 32'(if_pc), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        rst = 1'b0;
        log_q.delete();
        step(3);
        check_log(0, 9'h000, 16'h1234);

        // Randomised traffic checked continuously by the monitor.
        for (int i = 0; i < 2000; i++) begin
            if_ready    = ($urandom_range(0, 9) < 7);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = 9'($urandom);
            if ($urandom_range(0, 9) == 0) halt = ~halt;
            rst         = ($urandom_range(0, 99) == 0);
            step(1);
        end
        rst = 1'b0; redirect = 1'b0; halt = 1'b0;
        step(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
